// File: rtl/sifh_hist_readout_pkg.sv
// Shared widths and scan states for the SiFH histogram readout.
// Defaults mirror the SiFH width header.
package sifh_hist_readout_pkg;

  localparam int PEAK_MAX_DFLT     = 10;
  localparam int BIN_BITS_DFLT     = 4;
  localparam int PIX_BITS_DFLT     = 2;
  localparam int RAM_ADDR_DFLT     = PIX_BITS_DFLT + BIN_BITS_DFLT;
  localparam int PIXEL_NUM_PER_RAM = 1 << PIX_BITS_DFLT;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sifh_hist_readout_if.sv
// Peak result stream: {pixel, bin, count} over valid/ready.
// Master drives the result, slave drives ready.
interface sifh_hist_readout_if
  import sifh_hist_readout_pkg::*;
#(
  parameter int PIX_BITS = PIX_BITS_DFLT,
  parameter int BIN_BITS = BIN_BITS_DFLT,
  parameter int PEAK_MAX = PEAK_MAX_DFLT
);

  logic                pk_valid;
  logic                pk_ready;
  logic [PIX_BITS-1:0] pk_pixel;
  logic [BIN_BITS-1:0] pk_bin;
  logic [PEAK_MAX-1:0] pk_count;

  modport master (
    output pk_valid,
    output pk_pixel,
    output pk_bin,
    output pk_count,
    input  pk_ready
  );

  modport slave (
    input  pk_valid,
    input  pk_pixel,
    input  pk_bin,
    input  pk_count,
    output pk_ready
  );

endinterface

// File: rtl/sifh_peak_cmp.sv
// Running-max register with bin tag; strictly-greater update
// keeps the lowest bin on ties.
module sifh_peak_cmp
  import sifh_hist_readout_pkg::*;
#(
  parameter int PEAK_MAX = PEAK_MAX_DFLT,
  parameter int BIN_BITS = BIN_BITS_DFLT
) (
  input  logic                clk,
  input  logic                res,
  input  logic                init_i,
  input  logic                en_i,
  input  logic [PEAK_MAX-1:0] data_i,
  input  logic [BIN_BITS-1:0] bin_i,
  output logic [PEAK_MAX-1:0] max_o,
  output logic [BIN_BITS-1:0] bin_o
);

  logic [PEAK_MAX-1:0] max_q, max_d;
  logic [BIN_BITS-1:0] bin_q, bin_d;
  logic                upd;

  assign upd = !init_i && en_i && (data_i > max_q);

  always_comb begin
    max_d = max_q;
    bin_d = bin_q;
    unique case (1'b1)
      init_i: begin
        max_d = '0;
        bin_d = '0;
      end
      upd: begin
        max_d = data_i;
        bin_d = bin_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      max_q <= '0;
      bin_q <= '0;
    end else begin
      max_q <= max_d;
      bin_q <= bin_d;
    end
  end

  assign max_o = max_q;
  assign bin_o = bin_q;

endmodule

// File: rtl/sifh_hist_readout.sv
// Scans the histogram SRAM pixel by pixel, streams each pixel's
// peak bin and optionally zeroes every bin behind the read.
module sifh_hist_readout
  import sifh_hist_readout_pkg::*;
#(
  parameter int PEAK_MAX = PEAK_MAX_DFLT,
  parameter int BIN_BITS = BIN_BITS_DFLT,
  parameter int PIX_BITS = PIX_BITS_DFLT,
  parameter int RAM_ADDR = PIX_BITS + BIN_BITS
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic                clear_en,
  output logic                busy,
  output logic                done,
  output logic [RAM_ADDR-1:0] ram_raddr,
  output logic                ram_ren,
  input  logic [PEAK_MAX-1:0] ram_rdata,
  output logic [RAM_ADDR-1:0] ram_waddr,
  output logic                ram_wen,
  output logic [PEAK_MAX-1:0] ram_wdata,
  sifh_hist_readout_if.master pk
);

  localparam logic [BIN_BITS-1:0] BIN_LAST = '1;
  localparam logic [PIX_BITS-1:0] PIX_LAST = '1;

  state_e              state_q, state_d;
  logic [PIX_BITS-1:0] pix_q, pix_d;
  logic [BIN_BITS-1:0] bin_q, bin_d;
  logic                clr_q, clr_d;
  logic                rvld_q;
  logic [RAM_ADDR-1:0] raddr_q;
  logic                rd_go;
  logic                emit;
  logic                pk_init;
  logic [PEAK_MAX-1:0] max_cnt;
  logic [BIN_BITS-1:0] max_bin;

  assign rd_go   = (state_q == S_READ);
  assign emit    = (state_q == S_EMIT);
  assign pk_init = rd_go && (bin_q == '0);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    bin_d   = bin_q;
    clr_d   = clr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          pix_d   = '0;
          bin_d   = '0;
          clr_d   = clear_en;
        end
      end
      S_READ: begin
        bin_d = bin_q + 1'b1;
        if (bin_q == BIN_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        // Next pixel is only fetched once this result is taken
        if (pk.pk_ready) begin
          if (pix_q == PIX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            pix_d   = pix_q + 1'b1;
            bin_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      bin_q   <= '0;
      clr_q   <= 1'b0;
      rvld_q  <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      bin_q   <= bin_d;
      clr_q   <= clr_d;
      rvld_q  <= rd_go;
      if (rd_go) raddr_q <= {pix_q, bin_q};
    end
  end

  sifh_peak_cmp #(
    .PEAK_MAX (PEAK_MAX),
    .BIN_BITS (BIN_BITS)
  ) u_peak (
    .clk    (clk),
    .res    (res),
    .init_i (pk_init),
    .en_i   (rvld_q),
    .data_i (ram_rdata),
    .bin_i  (raddr_q[BIN_BITS-1:0]),
    .max_o  (max_cnt),
    .bin_o  (max_bin)
  );

  assign busy      = (state_q == S_READ) ||
                     (state_q == S_DRAIN) ||
                     (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
  assign ram_ren   = rd_go;
  assign ram_raddr = rd_go ? {pix_q, bin_q} : '0;

  // Clear the word whose data is returning, one behind the read
  assign ram_wen   = rvld_q && clr_q;
  assign ram_waddr = ram_wen ? raddr_q : '0;
  assign ram_wdata = '0;

  assign pk.pk_valid = emit;
  assign pk.pk_pixel = emit ? pix_q : '0;
  assign pk.pk_bin   = emit ? max_bin : '0;
  assign pk.pk_count = emit ? max_cnt : '0;

endmodule

// File: tb/tb_sifh_hist_readout.sv
// Bench for sifh_hist_readout: 1-cycle RAM model and a
// scoreboard of per-pixel peaks computed from the model memory.
module tb_sifh_hist_readout;
  import sifh_hist_readout_pkg::*;

  localparam int PM = PEAK_MAX_DFLT;
  localparam int BB = BIN_BITS_DFLT;
  localparam int PB = PIX_BITS_DFLT;
  localparam int AW = PB + BB;
  localparam int NW = 1 << AW;
  localparam int NB = 1 << BB;
  localparam int NP = 1 << PB;

  typedef logic [PB+BB+PM-1:0] res_t;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic          clear_en = 1'b0;
  logic          busy, done, ram_ren, ram_wen;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [PM-1:0] ram_rdata, ram_wdata;

  sifh_hist_readout_if #(
    .PIX_BITS(PB), .BIN_BITS(BB), .PEAK_MAX(PM)
  ) pk ();

  sifh_hist_readout dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .clear_en  (clear_en),
    .busy      (busy),
    .done      (done),
    .ram_raddr (ram_raddr),
    .ram_ren   (ram_ren),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wen   (ram_wen),
    .ram_wdata (ram_wdata),
    .pk        (pk)
  );

  always #5 clk = ~clk;

  logic [PM-1:0] mem [NW];
  logic [PM-1:0] img [NW];
  int wcnt [NW];
  int ren_total, wen_total, wbad, cyc;
  bit do_load = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (do_load) begin
      for (int i = 0; i < NW; i++) begin
        mem[i]  <= img[i];
        wcnt[i] <= 0;
      end
    end else begin
      if (ram_ren) begin
        ram_rdata <= mem[ram_raddr];
        ren_total <= ren_total + 1;
      end
      if (ram_wen) begin
        mem[ram_waddr]  <= ram_wdata;
        wcnt[ram_waddr] <= wcnt[ram_waddr] + 1;
        wen_total       <= wen_total + 1;
        if (ram_wdata != '0 ||
            (ram_ren && ram_raddr == ram_waddr))
          wbad <= wbad + 1;
      end
    end
  end

  int n_cmp, n_bad;
  res_t exp_q[$];
  res_t got_q[$];
  int first_ren, first_vld, done_cnt, busy_at_done;
  int unstable, stall_ren, ren_n, wen_n;
  bit timed_out;

  function automatic res_t model_peak(input int p);
    logic [PM-1:0] mx;
    logic [BB-1:0] mb;
    logic [PB-1:0] pp;
    mx = '0;
    mb = '0;
    pp = p[PB-1:0];
    for (int b = 0; b < NB; b++) begin
      if (mem[p*NB+b] > mx) begin
        mx = mem[p*NB+b];
        mb = b[BB-1:0];
      end
    end
    return {pp, mb, mx};
  endfunction

  task automatic load_img(input bit zero);
    for (int i = 0; i < NW; i++) img[i] = '0;
    if (!zero) begin
      img[5]     = 10'd7;
      img[16+1]  = 10'd5;
      img[16+3]  = 10'd20;
      img[16+9]  = 10'd20;
      img[32+0]  = 10'd1022;
      img[32+15] = 10'd1023;
      for (int b = 0; b < NB; b++)
        img[48+b] = PM'($urandom_range(0, 1023));
    end
    @(negedge clk);
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic run_scan(input logic clr, input int stall,
                          input bit poke);
    int   left, post, r0, w0;
    bit   seen;
    res_t snap, cur;
    left = stall;
    post = 0;
    seen = 1'b0;
    snap = '0;
    got_q.delete();
    exp_q.delete();
    for (int p = 0; p < NP; p++) exp_q.push_back(model_peak(p));
    first_ren = -1;
    first_vld = -1;
    done_cnt = 0;
    busy_at_done = 0;
    unstable = 0;
    stall_ren = 0;
    timed_out = 1'b0;
    r0 = ren_total;
    w0 = wen_total;
    pk.pk_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    clear_en = clr;
    @(negedge clk);
    start = 1'b0;
    clear_en = ~clr;
    for (int n = 0; n < 2000; n++) begin
      cur = {pk.pk_pixel, pk.pk_bin, pk.pk_count};
      if (ram_ren && first_ren < 0) first_ren = cyc;
      if (pk.pk_valid && first_vld < 0) first_vld = cyc;
      if (done) begin
        done_cnt++;
        if (busy) busy_at_done++;
        seen = 1'b1;
      end
      if (pk.pk_valid && !pk.pk_ready) begin
        if (cur !== snap) unstable++;
        if (ram_ren) stall_ren++;
      end
      if (pk.pk_valid && pk.pk_ready) got_q.push_back(cur);
      start = poke && (n == 40);
      if (pk.pk_valid && left > 0 && got_q.size() == 0) begin
        snap = cur;
        pk.pk_ready = 1'b0;
        left--;
      end else begin
        pk.pk_ready = 1'b1;
      end
      if (seen) post++;
      if (post > 6) break;
      @(negedge clk);
    end
    timed_out = !seen;
    pk.pk_ready = 1'b1;
    start = 1'b0;
    clear_en = 1'b0;
    ren_n = ren_total - r0;
    wen_n = wen_total - w0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    pk.pk_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, ram_ren, ram_wen, pk.pk_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 00000",
               {busy, done, ram_ren, ram_wen, pk.pk_valid});
    end
    n_cmp++;
    if ({ram_raddr, ram_waddr, ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_ram: got %h want 0",
               {ram_raddr, ram_waddr, ram_wdata});
    end
    n_cmp++;
    if ({pk.pk_pixel, pk.pk_bin, pk.pk_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_pk: got %h want 0",
               {pk.pk_pixel, pk.pk_bin, pk.pk_count});
    end
    res = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    res_t e, g;
    int diff;
    load_img(1'b0);
    run_scan(1'b0, 0, 1'b0);
    n_cmp++;
    if (timed_out) begin
      n_bad++;
      $display("FAIL basic_timeout: got no done want done");
    end
    n_cmp++;
    if (got_q.size() != NP) begin
      n_bad++;
      $display("FAIL basic_count: got %0d want %0d",
               got_q.size(), NP);
    end
    if (got_q.size() == NP) begin
      n_cmp++;
      if (got_q[0] !== {2'd0, 4'd5, 10'd7}) begin
        n_bad++;
        $display("FAIL basic_pix0: got %h want %h",
                 got_q[0], {2'd0, 4'd5, 10'd7});
      end
      n_cmp++;
      if (got_q[1] !== {2'd1, 4'd3, 10'd20}) begin
        n_bad++;
        $display("FAIL tie_pix1: got %h want %h",
                 got_q[1], {2'd1, 4'd3, 10'd20});
      end
      n_cmp++;
      if (got_q[2] !== {2'd2, 4'd15, 10'd1023}) begin
        n_bad++;
        $display("FAIL sat_pix2: got %h want %h",
                 got_q[2], {2'd2, 4'd15, 10'd1023});
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL basic_result: got %h want %h", g, e);
      end
    end
    n_cmp++;
    if (first_vld - first_ren != NB + 1) begin
      n_bad++;
      $display("FAIL latency: got %0d want %0d",
               first_vld - first_ren, NB + 1);
    end
    n_cmp++;
    if (done_cnt != 1 || busy_at_done != 0) begin
      n_bad++;
      $display("FAIL done_pulse: got %0d/%0d want 1/0",
               done_cnt, busy_at_done);
    end
    n_cmp++;
    if (wen_n != 0 || ren_n != NW) begin
      n_bad++;
      $display("FAIL noclr_ram: got wen %0d ren %0d want 0 %0d",
               wen_n, ren_n, NW);
    end
    diff = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== img[i]) diff++;
    n_cmp++;
    if (diff != 0) begin
      n_bad++;
      $display("FAIL noclr_mem: got %0d changed want 0", diff);
    end
  endtask

  task automatic test_stall();
    res_t e, g;
    load_img(1'b0);
    run_scan(1'b0, 10, 1'b0);
    n_cmp++;
    if (timed_out || got_q.size() != NP) begin
      n_bad++;
      $display("FAIL stall_count: got %0d want %0d",
               got_q.size(), NP);
    end
    n_cmp++;
    if (unstable != 0 || stall_ren != 0) begin
      n_bad++;
      $display("FAIL stall_hold: got chg %0d ren %0d want 0 0",
               unstable, stall_ren);
    end
    n_cmp++;
    if (ren_n != NW) begin
      n_bad++;
      $display("FAIL stall_reads: got %0d want %0d", ren_n, NW);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL stall_result: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_clear();
    res_t e, g;
    int nz, bad;
    load_img(1'b0);
    run_scan(1'b1, 0, 1'b0);
    n_cmp++;
    if (timed_out || got_q.size() != NP) begin
      n_bad++;
      $display("FAIL clr_count: got %0d want %0d",
               got_q.size(), NP);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL clr_result: got %h want %h", g, e);
      end
    end
    nz = 0;
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (mem[i] !== '0) nz++;
      if (wcnt[i] != 1) bad++;
    end
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL clr_mem: got %0d nonzero want 0", nz);
    end
    n_cmp++;
    if (bad != 0 || wen_n != NW || wbad != 0) begin
      n_bad++;
      $display("FAIL clr_writes: got %0d/%0d/%0d want 0/%0d/0",
               bad, wen_n, wbad, NW);
    end
    run_scan(1'b0, 0, 1'b0);
    n_cmp++;
    if (timed_out || got_q.size() != NP) begin
      n_bad++;
      $display("FAIL zero_count: got %0d want %0d",
               got_q.size(), NP);
    end
    for (int p = 0; p < NP && got_q.size() > 0; p++) begin
      g = got_q.pop_front();
      e = {p[PB-1:0], {BB{1'b0}}, {PM{1'b0}}};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL zero_result: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_busy_start();
    res_t e, g;
    load_img(1'b0);
    run_scan(1'b0, 0, 1'b1);
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL busy_done: got %0d want 1", done_cnt);
    end
    n_cmp++;
    if (got_q.size() != NP || ren_n != NW) begin
      n_bad++;
      $display("FAIL busy_count: got %0d/%0d want %0d/%0d",
               got_q.size(), ren_n, NP, NW);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL busy_result: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t e, g;
    bit   hit;
    load_img(1'b0);
    pk.pk_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      if (ram_ren && ram_raddr[AW-1:BB] == 2'd2) hit = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL rmid_reach: got no pixel 2 read want read");
    end
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, ram_ren, ram_wen, pk.pk_valid,
         ram_raddr, ram_waddr, ram_wdata,
         pk.pk_pixel, pk.pk_bin, pk.pk_count} !== '0) begin
      n_bad++;
      $display("FAIL rmid_outs: got busy %b ren %b addr %h want 0",
               busy, ram_ren, ram_raddr);
    end
    @(negedge clk);
    res = 1'b1;
    run_scan(1'b0, 0, 1'b0);
    n_cmp++;
    if (timed_out || got_q.size() != NP) begin
      n_bad++;
      $display("FAIL rmid_count: got %0d want %0d",
               got_q.size(), NP);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL rmid_result: got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pk.pk_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_clear();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
